// File: rtl/axi4_xbar_1to2.sv
// axi4_xbar_1to2: AXI4 1-master/2-slave crossbar (SRAM on m0, UART on m1) with a local DECERR responder.
module axi4_xbar_1to2 #(
  parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] SRAM_MASK = 32'hF800_0000,
  parameter logic [31:0] UART_BASE = 32'h1000_0000,
  parameter logic [31:0] UART_MASK = 32'hFFFF_F000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [3:0]  s_awid,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  output logic [3:0]  s_bid,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [1:0]  s_rresp,
  output logic [31:0] s_rdata,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  output logic        m0_awvalid,
  input  logic        m0_awready,
  output logic [31:0] m0_awaddr,
  output logic [3:0]  m0_awid,
  output logic [7:0]  m0_awlen,
  output logic [2:0]  m0_awsize,
  output logic [1:0]  m0_awburst,
  output logic        m0_wvalid,
  input  logic        m0_wready,
  output logic [31:0] m0_wdata,
  output logic [3:0]  m0_wstrb,
  output logic        m0_wlast,
  input  logic        m0_bvalid,
  output logic        m0_bready,
  input  logic [1:0]  m0_bresp,
  input  logic [3:0]  m0_bid,
  output logic        m0_arvalid,
  input  logic        m0_arready,
  output logic [31:0] m0_araddr,
  output logic [3:0]  m0_arid,
  output logic [7:0]  m0_arlen,
  output logic [2:0]  m0_arsize,
  output logic [1:0]  m0_arburst,
  input  logic        m0_rvalid,
  output logic        m0_rready,
  input  logic [1:0]  m0_rresp,
  input  logic [31:0] m0_rdata,
  input  logic        m0_rlast,
  input  logic [3:0]  m0_rid,
  output logic        m1_awvalid,
  input  logic        m1_awready,
  output logic [31:0] m1_awaddr,
  output logic [3:0]  m1_awid,
  output logic [7:0]  m1_awlen,
  output logic [2:0]  m1_awsize,
  output logic [1:0]  m1_awburst,
  output logic        m1_wvalid,
  input  logic        m1_wready,
  output logic [31:0] m1_wdata,
  output logic [3:0]  m1_wstrb,
  output logic        m1_wlast,
  input  logic        m1_bvalid,
  output logic        m1_bready,
  input  logic [1:0]  m1_bresp,
  input  logic [3:0]  m1_bid,
  output logic        m1_arvalid,
  input  logic        m1_arready,
  output logic [31:0] m1_araddr,
  output logic [3:0]  m1_arid,
  output logic [7:0]  m1_arlen,
  output logic [2:0]  m1_arsize,
  output logic [1:0]  m1_arburst,
  input  logic        m1_rvalid,
  output logic        m1_rready,
  input  logic [1:0]  m1_rresp,
  input  logic [31:0] m1_rdata,
  input  logic        m1_rlast,
  input  logic [3:0]  m1_rid
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  r_state_t rs, rs_n;
  w_state_t ws, ws_n;
  logic [31:0] ar_addr, aw_addr;
  logic [3:0]  ar_id, aw_id;
  logic [7:0]  ar_len, aw_len, r_cnt;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst, ar_dec, aw_dec;
  logic        ar_sel, ar_err, aw_sel, aw_err;
  // {err, sel}: the UART window wins where the two windows overlap
  function automatic logic [1:0] decode(input logic [31:0] a);
    return ((a & UART_MASK) == UART_BASE) ? 2'b01 : ((a & SRAM_MASK) == SRAM_BASE) ? 2'b00 : 2'b10;
  endfunction
  assign ar_dec = decode(s_araddr);
  assign aw_dec = decode(s_awaddr);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs <= R_IDLE;
      ws <= W_IDLE;
      {ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_err, ar_sel} <= '0;
      {aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_err, aw_sel} <= '0;
      r_cnt <= '0;
    end else begin
      rs <= rs_n;
      ws <= ws_n;
      if (s_arvalid && s_arready)
        {ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_err, ar_sel} <= {s_araddr, s_arid, s_arlen, s_arsize, s_arburst, ar_dec};
      if (s_awvalid && s_awready)
        {aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_err, aw_sel} <= {s_awaddr, s_awid, s_awlen, s_awsize, s_awburst, aw_dec};
      r_cnt <= (rs == R_IDLE) ? 8'd0 : (ar_err && s_rvalid && s_rready) ? r_cnt + 8'd1 : r_cnt;
    end
  end
  assign s_arready  = rs == R_IDLE;
  assign m0_arvalid = rs == R_ADDR && !ar_sel;
  assign m1_arvalid = rs == R_ADDR && ar_sel;
  assign {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = {ar_addr, ar_id, ar_len, ar_size, ar_burst};
  assign {m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = {ar_addr, ar_id, ar_len, ar_size, ar_burst};
  assign s_rvalid  = rs == R_DATA && (ar_err || (ar_sel ? m1_rvalid : m0_rvalid));
  assign s_rdata   = ar_err ? 32'd0 : ar_sel ? m1_rdata : m0_rdata;
  assign s_rresp   = ar_err ? 2'b11 : ar_sel ? m1_rresp : m0_rresp;
  assign s_rid     = ar_err ? ar_id : ar_sel ? m1_rid : m0_rid;
  assign s_rlast   = ar_err ? r_cnt == ar_len : ar_sel ? m1_rlast : m0_rlast;
  assign m0_rready = rs == R_DATA && !ar_err && !ar_sel && s_rready;
  assign m1_rready = rs == R_DATA && !ar_err && ar_sel && s_rready;
  always_comb begin
    rs_n = rs;
    unique case (rs)
      R_IDLE:  if (s_arvalid) rs_n = ar_dec[1] ? R_DATA : R_ADDR;
      R_ADDR:  if (ar_sel ? m1_arready : m0_arready) rs_n = R_DATA;
      R_DATA:  if (s_rvalid && s_rready && s_rlast) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end
  assign s_awready  = ws == W_IDLE;
  assign m0_awvalid = ws == W_ADDR && !aw_sel;
  assign m1_awvalid = ws == W_ADDR && aw_sel;
  assign {m0_awaddr, m0_awid, m0_awlen, m0_awsize, m0_awburst} = {aw_addr, aw_id, aw_len, aw_size, aw_burst};
  assign {m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = {aw_addr, aw_id, aw_len, aw_size, aw_burst};
  assign s_wready  = ws == W_DATA && (aw_err || (aw_sel ? m1_wready : m0_wready));
  assign m0_wvalid = ws == W_DATA && !aw_err && !aw_sel && s_wvalid;
  assign m1_wvalid = ws == W_DATA && !aw_err && aw_sel && s_wvalid;
  assign {m0_wdata, m0_wstrb, m0_wlast} = {s_wdata, s_wstrb, s_wlast};
  assign {m1_wdata, m1_wstrb, m1_wlast} = {s_wdata, s_wstrb, s_wlast};
  assign s_bvalid  = ws == W_RESP && (aw_err || (aw_sel ? m1_bvalid : m0_bvalid));
  assign s_bresp   = aw_err ? 2'b11 : aw_sel ? m1_bresp : m0_bresp;
  assign s_bid     = aw_err ? aw_id : aw_sel ? m1_bid : m0_bid;
  assign m0_bready = ws == W_RESP && !aw_err && !aw_sel && s_bready;
  assign m1_bready = ws == W_RESP && !aw_err && aw_sel && s_bready;
  always_comb begin
    ws_n = ws;
    unique case (ws)
      W_IDLE:  if (s_awvalid) ws_n = aw_dec[1] ? W_DATA : W_ADDR;
      W_ADDR:  if (aw_sel ? m1_awready : m0_awready) ws_n = W_DATA;
      W_DATA:  if (s_wvalid && s_wready && s_wlast) ws_n = W_RESP;
      default: if (s_bvalid && s_bready) ws_n = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4_xbar_1to2.sv
// tb_axi4_xbar_1to2: scoreboard bench with randomised SRAM/UART slave models behind the crossbar.
module tb_axi4_xbar_1to2;
  logic clock = 0, reset = 0;
  always #5 clock = ~clock;
  logic s_awvalid = 0, s_wvalid = 0, s_wlast = 0, s_bready = 1, s_arvalid = 0, s_rready = 1;
  logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
  logic [3:0] s_awid = 0, s_wstrb = 0, s_arid = 0;
  logic [7:0] s_awlen = 0, s_arlen = 0;
  logic [2:0] s_awsize = 0, s_arsize = 0;
  logic [1:0] s_awburst = 0, s_arburst = 0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [1:0] s_bresp, s_rresp;
  logic [3:0] s_bid, s_rid;
  logic [31:0] s_rdata;
  logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, m_awvalid, m_awready;
  logic [1:0] m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_araddr[2], m_rdata[2], m_awaddr[2], m_wdata[2];
  logic [3:0] m_arid[2], m_rid[2], m_awid[2], m_bid[2], m_wstrb[2];
  logic [7:0] m_arlen[2], m_awlen[2];
  logic [2:0] m_arsize[2], m_awsize[2];
  logic [1:0] m_arburst[2], m_awburst[2], m_rresp[2], m_bresp[2];
  logic [44:0] arq[2][$], awq[2][$];
  logic [36:0] wq[2][$];
  logic [38:0] rq[$];
  logic [5:0] bq[$];
  logic [44:0] ea;
  logic [36:0] ew;
  logic [38:0] er;
  logic [5:0] eb;
  logic [1:0] rd_active = 0, w_busy = 0, w_active = 0, b_pend = 0, r_hs = 0, b_hs = 0, ar_hold = 0, saw_arv = 0, saw_awv = 0;
  logic [31:0] rd_addr[2], hold_addr[2];
  logic [7:0] rd_len[2], beat[2];
  logic [3:0] rd_id[2], w_id[2];
  int ar_cnt[2], aw_cnt[2];
  int rbeats = 0, total = 0, bad = 0;
  bit rnd = 1, tog = 0;

  axi4_xbar_1to2 dut (
    .clock(clock), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rid(s_rid),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]), .m0_awid(m_awid[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(m_bresp[0]), .m0_bid(m_bid[0]),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]), .m0_arid(m_arid[0]), .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]), .m0_arburst(m_arburst[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rresp(m_rresp[0]), .m0_rdata(m_rdata[0]), .m0_rlast(m_rlast[0]), .m0_rid(m_rid[0]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]), .m1_awid(m_awid[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(m_bresp[1]), .m1_bid(m_bid[1]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]), .m1_arid(m_arid[1]), .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]), .m1_arburst(m_arburst[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rresp(m_rresp[1]), .m1_rdata(m_rdata[1]), .m1_rlast(m_rlast[1]), .m1_rid(m_rid[1])
  );

  function automatic int dec(input logic [31:0] a);
    if ((a & 32'hFFFF_F000) == 32'h1000_0000) return 1;
    if ((a & 32'hF800_0000) == 32'h8000_0000) return 0;
    return 2;
  endfunction
  function automatic logic [31:0] rpat(input int p, input logic [31:0] a, input logic [7:0] b);
    return a ^ {b, 24'h0} ^ (p == 1 ? 32'h005A_A500 : 32'h0000_00C3);
  endfunction

  // slave models: drive on the falling edge, observe handshakes on the rising edge
  always @(negedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (!reset) begin
        {m_arready[p], m_rvalid[p], m_rlast[p], m_awready[p], m_wready[p], m_bvalid[p], r_hs[p], b_hs[p]} = '0;
        m_rdata[p] = 0; m_rresp[p] = 0; m_rid[p] = 0; m_bresp[p] = 0; m_bid[p] = 0;
      end else begin
        m_arready[p] = !rd_active[p] && (!rnd || $urandom_range(0, 1) == 1);
        m_rvalid[p] = rd_active[p] && ((m_rvalid[p] && !r_hs[p]) || !rnd || $urandom_range(0, 2) != 0);
        r_hs[p] = 0;
        m_rdata[p] = rpat(p, rd_addr[p], beat[p]);
        m_rresp[p] = 0;
        m_rid[p] = rd_id[p];
        m_rlast[p] = beat[p] == rd_len[p];
        m_awready[p] = !w_busy[p] && (!rnd || $urandom_range(0, 1) == 1);
        m_wready[p] = w_active[p] && (!rnd || $urandom_range(0, 2) != 0);
        m_bvalid[p] = b_pend[p] && ((m_bvalid[p] && !b_hs[p]) || !rnd || $urandom_range(0, 1) == 1);
        b_hs[p] = 0;
        m_bresp[p] = 0;
        m_bid[p] = w_id[p];
      end
    end
    s_rready = tog ? ~s_rready : 1'b1;
    s_bready = tog ? ~s_bready : 1'b1;
  end

  always @(posedge clock) begin
    if (!reset) begin
      rd_active = 0; w_busy = 0; w_active = 0; b_pend = 0; ar_hold = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        saw_arv[p] = saw_arv[p] | m_arvalid[p];
        saw_awv[p] = saw_awv[p] | m_awvalid[p];
        if (ar_hold[p]) begin
          total++;
          if (m_arvalid[p] !== 1'b1 || m_araddr[p] !== hold_addr[p]) begin
            bad++; $display("FAIL ar_stable p%0d got=%b/%h exp=1/%h", p, m_arvalid[p], m_araddr[p], hold_addr[p]);
          end
        end
        ar_hold[p] = m_arvalid[p] && !m_arready[p];
        hold_addr[p] = m_araddr[p];
        if (m_arvalid[p] && m_arready[p]) begin
          ar_cnt[p]++; rd_active[p] = 1; beat[p] = 0;
          rd_addr[p] = m_araddr[p]; rd_len[p] = m_arlen[p]; rd_id[p] = m_arid[p];
          total++;
          if (arq[p].size() == 0) begin
            bad++; $display("FAIL ar_unexpected p%0d got=%h exp=none", p, m_araddr[p]);
          end else begin
            ea = arq[p].pop_front();
            if ({m_araddr[p], m_arlen[p], m_arsize[p], m_arburst[p]} !== ea) begin
              bad++; $display("FAIL ar_fields p%0d got=%h exp=%h", p, {m_araddr[p], m_arlen[p], m_arsize[p], m_arburst[p]}, ea);
            end
          end
        end
        if (m_rvalid[p] && m_rready[p]) begin
          r_hs[p] = 1;
          if (m_rlast[p]) rd_active[p] = 0;
          beat[p]++;
        end
        if (m_awvalid[p] && m_awready[p]) begin
          aw_cnt[p]++; w_busy[p] = 1; w_active[p] = 1; w_id[p] = m_awid[p];
          total++;
          if (awq[p].size() == 0) begin
            bad++; $display("FAIL aw_unexpected p%0d got=%h exp=none", p, m_awaddr[p]);
          end else begin
            ea = awq[p].pop_front();
            if ({m_awaddr[p], m_awlen[p], m_awsize[p], m_awburst[p]} !== ea) begin
              bad++; $display("FAIL aw_fields p%0d got=%h exp=%h", p, {m_awaddr[p], m_awlen[p], m_awsize[p], m_awburst[p]}, ea);
            end
          end
        end
        if (m_wvalid[p] && m_wready[p]) begin
          total++;
          if (wq[p].size() == 0) begin
            bad++; $display("FAIL w_unexpected p%0d got=%h exp=none", p, m_wdata[p]);
          end else begin
            ew = wq[p].pop_front();
            if ({m_wdata[p], m_wstrb[p], m_wlast[p]} !== ew) begin
              bad++; $display("FAIL w_beat p%0d got=%h exp=%h", p, {m_wdata[p], m_wstrb[p], m_wlast[p]}, ew);
            end
          end
          if (m_wlast[p]) begin w_active[p] = 0; b_pend[p] = 1; end
        end
        if (m_bvalid[p] && m_bready[p]) begin b_hs[p] = 1; b_pend[p] = 0; w_busy[p] = 0; end
      end
      if (s_rvalid && s_rready) begin
        rbeats++; total++;
        if (rq.size() == 0) begin
          bad++; $display("FAIL r_unexpected got=%h exp=none", {s_rdata, s_rresp, s_rid, s_rlast});
        end else begin
          er = rq.pop_front();
          if ({s_rdata, s_rresp, s_rid, s_rlast} !== er) begin
            bad++; $display("FAIL r_beat got=%h exp=%h", {s_rdata, s_rresp, s_rid, s_rlast}, er);
          end
        end
      end
      if (s_bvalid && s_bready) begin
        total++;
        if (bq.size() == 0) begin
          bad++; $display("FAIL b_unexpected got=%h exp=none", {s_bresp, s_bid});
        end else begin
          eb = bq.pop_front();
          if ({s_bresp, s_bid} !== eb) begin
            bad++; $display("FAIL b_resp got=%h exp=%h", {s_bresp, s_bid}, eb);
          end
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int p = dec(a), n = 0;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back({(p == 2) ? 32'h0 : rpat(p, a, 8'(i)), (p == 2) ? 2'b11 : 2'b00, id, i == int'(len)});
    if (p < 2) arq[p].push_back({a, len, 3'd2, 2'd1});
    @(negedge clock);
    s_arvalid = 1; s_araddr = a; s_arid = id; s_arlen = len; s_arsize = 3'd2; s_arburst = 2'd1;
    #1;
    while (!s_arready && n < 1000) begin @(negedge clock); #1; n++; end
    if (n >= 1000) begin total++; bad++; $display("FAIL ar_accept_timeout got=%0d exp=<1000", n); end
    @(negedge clock);
    s_arvalid = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [31:0] d0, input logic [3:0] strb);
    int p = dec(a);
    bq.push_back({(p == 2) ? 2'b11 : 2'b00, id});
    if (p < 2) begin
      awq[p].push_back({a, len, 3'd2, 2'd1});
      for (int i = 0; i <= int'(len); i++) wq[p].push_back({d0 + 32'(i), strb, i == int'(len)});
    end
    fork
      begin
        int n = 0;
        @(negedge clock);
        s_awvalid = 1; s_awaddr = a; s_awid = id; s_awlen = len; s_awsize = 3'd2; s_awburst = 2'd1;
        #1;
        while (!s_awready && n < 1000) begin @(negedge clock); #1; n++; end
        if (n >= 1000) begin total++; bad++; $display("FAIL aw_accept_timeout got=%0d exp=<1000", n); end
        @(negedge clock);
        s_awvalid = 0;
      end
      begin
        for (int i = 0; i <= int'(len); i++) begin
          int n = 0;
          @(negedge clock);
          s_wvalid = 1; s_wdata = d0 + 32'(i); s_wstrb = strb; s_wlast = i == int'(len);
          #1;
          while (!s_wready && n < 1000) begin @(negedge clock); #1; n++; end
          if (n >= 1000) begin total++; bad++; $display("FAIL w_accept_timeout got=%0d exp=<1000", n); end
        end
        @(negedge clock);
        s_wvalid = 0; s_wlast = 0;
      end
    join
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 5000) begin @(negedge clock); n++; end
    total++;
    if (n >= 5000) begin bad++; $display("FAIL drain_timeout got=r%0d/b%0d exp=0/0", rq.size(), bq.size()); end
  endtask

  task automatic clear_counts();
    ar_cnt = '{0, 0}; aw_cnt = '{0, 0}; saw_arv = 0; saw_awv = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    total++;
    if ({s_arready, s_awready} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", {s_arready, s_awready}); end
    total++;
    if ({s_rvalid, s_bvalid, s_wready} !== 3'b000) begin bad++; $display("FAIL reset_s_valid got=%b exp=000", {s_rvalid, s_bvalid, s_wready}); end
    total++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 10'b0) begin
      bad++; $display("FAIL reset_m_ctrl got=%b exp=0", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready});
    end
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_sram_read();
    clear_counts();
    do_read(32'h8000_0010, 4'h2, 8'd3);
    #1;
    total++;
    if (s_arready !== 1'b0) begin bad++; $display("FAIL ar_backpressure got=%b exp=0", s_arready); end
    wait_idle();
    total++;
    if (ar_cnt[0] !== 1 || saw_arv[1] !== 1'b0) begin bad++; $display("FAIL sram_read_route got=%0d/%b exp=1/0", ar_cnt[0], saw_arv[1]); end
  endtask

  task automatic test_uart_write();
    clear_counts();
    do_write(32'h1000_0000, 4'h7, 8'd0, 32'h41, 4'b0001);
    wait_idle();
    total++;
    if (aw_cnt[1] !== 1 || saw_awv[0] !== 1'b0) begin bad++; $display("FAIL uart_write_route got=%0d/%b exp=1/0", aw_cnt[1], saw_awv[0]); end
  endtask

  task automatic test_err_read();
    clear_counts();
    do_read(32'h2000_0000, 4'h5, 8'd1);
    wait_idle();
    total++;
    if (saw_arv !== 2'b00) begin bad++; $display("FAIL err_read_arvalid got=%b exp=00", saw_arv); end
  endtask

  task automatic test_boundaries();
    int b0 = rbeats;
    clear_counts();
    do_read(32'h1000_0FFC, 4'h3, 8'd0);
    do_read(32'h87FF_FFFC, 4'h4, 8'd0);
    do_write(32'h8800_0000, 4'hA, 8'd2, 32'h1111_0000, 4'hF);
    do_write(32'h8000_0000, 4'hB, 8'd1, 32'h2222_0000, 4'h3);
    do_read(32'h1000_1000, 4'h6, 8'd255);
    wait_idle();
    total++;
    if (rbeats - b0 !== 258) begin bad++; $display("FAIL boundary_beats got=%0d exp=258", rbeats - b0); end
    total++;
    if (aw_cnt[0] !== 1 || aw_cnt[1] !== 0 || ar_cnt[0] !== 1 || ar_cnt[1] !== 1) begin
      bad++; $display("FAIL boundary_route got=%0d%0d%0d%0d exp=1011", aw_cnt[0], aw_cnt[1], ar_cnt[0], ar_cnt[1]);
    end
  endtask

  task automatic test_concurrent();
    tog = 1;
    fork
      do_read(32'h8000_0100, 4'h1, 8'd3);
      do_write(32'h1000_0008, 4'h9, 8'd1, 32'hCAFE_0000, 4'hF);
    join
    wait_idle();
    fork
      do_read(32'h8000_0200, 4'h2, 8'd2);
      do_write(32'h8000_0300, 4'h3, 8'd0, 32'h1234_5678, 4'hC);
    join
    wait_idle();
    tog = 0;
  endtask

  task automatic test_reset_mid_burst();
    int b0 = rbeats, n = 0;
    rnd = 0;
    do_read(32'h8000_0040, 4'hC, 8'd3);
    do begin @(negedge clock); n++; end while (rbeats < b0 + 1 && n < 100);
    #1;
    total++;
    if (s_rvalid !== 1'b1) begin bad++; $display("FAIL mid_burst_rvalid got=%b exp=1", s_rvalid); end
    reset = 0;
    #1;
    total++;
    if ({s_rvalid, m_rready[0], s_arready} !== 3'b001) begin
      bad++; $display("FAIL reset_abandon got=%b exp=001", {s_rvalid, m_rready[0], s_arready});
    end
    rq.delete(); bq.delete();
    for (int p = 0; p < 2; p++) begin arq[p].delete(); awq[p].delete(); wq[p].delete(); end
    repeat (2) @(negedge clock);
    reset = 1;
    rnd = 1;
    b0 = rbeats;
    do_read(32'h8000_0080, 4'hD, 8'd1);
    wait_idle();
    total++;
    if (rbeats - b0 !== 2) begin bad++; $display("FAIL post_reset_beats got=%0d exp=2", rbeats - b0); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sram_read();
    test_uart_write();
    test_err_read();
    test_boundaries();
    test_concurrent();
    test_reset_mid_burst();
    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_xbar_1to2.md
Name: axi4_xbar_1to2

Overview:
- AXI4 1-master/2-slave crossbar between the core's io_master port and the memory-side slaves: SRAM on port 0 and UART on port 1.
- Read and write paths are independent; each path has at most one outstanding transaction.
- Addresses outside both windows are answered locally with DECERR.

Parameters:
- SRAM_BASE, 32'h8000_0000, port-0 window base
- SRAM_MASK, 32'hF800_0000, port-0 window compare mask
- UART_BASE, 32'h1000_0000, port-1 window base
- UART_MASK, 32'hFFFF_F000, port-1 window compare mask

Ports:
- clock  in  1  single clock; rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- s_aw{valid,ready,addr,id,len,size,burst}  in/out/in...  1,1,32,4,8,3,2  upstream write address; ready is the only output
- s_w{valid,ready,data,strb,last}  in/out/in...  1,1,32,4,1  upstream write data
- s_b{valid,ready,resp,id}  out/in/out/out  1,1,2,4  upstream write response
- s_ar{valid,ready,addr,id,len,size,burst}  in/out/in...  1,1,32,4,8,3,2  upstream read address
- s_r{valid,ready,resp,data,last,id}  out/in/out...  1,1,2,32,1,4  upstream read data
- m0_* / m1_*  mirrored  same widths  full AXI4 master bundles toward SRAM (m0) and UART (m1)

Behaviour:
Decode
- sel = 1 if (addr & UART_MASK) == UART_BASE.
- Else sel = 0 if (addr & SRAM_MASK) == SRAM_BASE.
- Else ERR. UART decode takes priority.

Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE
- R_IDLE: s_arready = 1. On an s_ar handshake, latch addr/id/len/size/burst and the decoded sel, then go to R_ADDR (ERR goes straight to R_DATA).
- R_ADDR: drive the latched fields on m{sel}_ar with arvalid = 1; hold until m{sel}_arready, then go to R_DATA. Fields stay stable while valid is high.
- R_DATA, slave path: route m{sel}_r to s_r combinationally, including rready back to the slave. Leave on a handshake with rlast = 1.
- R_DATA, ERR path: emit latched len+1 beats with rresp = 2'b11, rdata = 0, rid = latched id. rlast is asserted on the final beat only. The beat counter is 8-bit and advances only on a handshake.
- The unselected slave sees arvalid = 0 and rready = 0.

Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE
- W_IDLE: s_awready = 1. Latch and decode exactly as on the read side.
- W_ADDR: drive m{sel}_aw until handshake (ERR skips this state).
- W_DATA: route s_w to m{sel}_w combinationally. Leave on a handshake with wlast = 1. ERR path: s_wready = 1 and the beats are discarded.
- W_RESP: route m{sel}_b to s_b. ERR path: bvalid = 1, bresp = 2'b11, bid = latched id. Return to W_IDLE on the s_b handshake.
- s_wready = 0 outside W_DATA. Write data presented before the address is accepted is held off, not dropped.

Reset (reset = 0, asynchronous)
- Both FSMs go to IDLE; latches and counter clear.
- All m*_valid, s_rvalid, s_bvalid, m*_rready, m*_bready and s_wready go to 0.
- s_arready and s_awready go to 1 (IDLE).
- Reset mid-burst abandons the transaction; no further beats are emitted.

Timing and boundaries
- Minimum latency is 1 cycle from the s_ar/s_aw handshake to m_ar/m_aw valid. The data channels add no latency.
- Simultaneous read and write to different slaves or the same slave proceed concurrently.
- s_arvalid arriving while not in R_IDLE is back-pressured (arready = 0).
- len = 0 gives a single beat with last set on that beat.
- len = 255 on the ERR path gives 256 beats with no counter overflow.
- Slave-path resp, id and last are passed through unmodified.

Test Plan:
- Read 0x8000_0010, len = 3 → m0_ar gets addr 0x8000_0010, len 3; 4 beats are relayed to s_r with rlast on beat 4; m1 stays idle.
- Write 0x1000_0000, wdata 0x41, wstrb 4'b0001 → m1_aw/w/b are exercised; s_bresp = 0 and bid = the issued id; m0 stays idle.
- Read 0x2000_0000, len = 1, id 5 → 2 local beats with rresp = 2'b11, rdata = 0, rid = 5; rlast on beat 2; no m*_arvalid.
- Concurrent read to SRAM and write to UART with s_rready toggling every cycle → both complete, the data is correct, and arvalid/addr stay stable under back-pressure.
- reset = 0 asserted in R_DATA beat 2 of 4 → s_rvalid drops immediately; after release s_arready = 1 and a new read completes normally.
